control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the 32-bit bus datapath. Steps fetch (T0-T2) and
//  execute (T3-T7) cycles, asserting datapath strobes from the instruction in IR.
//  Stretches memory cycles on mem_ready and halts on stop, halt or memory timeout.
//  Sits beside the datapath; its outputs drive the datapath control pins 1:1.
// PARAMETERS
//  OPW       5   opcode width, taken from ir[31:27]
//  WAIT_MAX  15  max cycles Read/Write may wait for mem_ready before mem_err
// PORTS
//  clk        in   1   system clock, rising edge
//  clr        in   1   asynchronous reset, active-low (clr=0 resets)
//  ir         in   32  instruction register contents
//  con_ff     in   1   branch condition flip-flop from datapath
//  mem_ready  in   1   memory completed current Read/Write
//  stop       in   1   halt request, sampled only in T0
//  PCout,Zlowout,MDRout,BAout,Cout,Rout  out 1 bus drive enables
//  PCin,IRin,MARin,MDRin,Yin,Zin,Rin,CONin out 1 register load enables
//  Gra,Grb,Grc  out 1  select IR Ra/Rb/Rc field for Rin/Rout
//  IncPC,Read,Write out 1 ALU increment / memory strobes
//  alu_op     out  5   ALU opcode (ADD=00011 for address/branch arithmetic)
//  run        out  1   1 while executing, 0 in RESET/HALT
//  mem_err    out  1   sticky, set on memory timeout
//  illegal    out  1   sticky, set on unknown opcode (macro only)
// BEHAVIOUR
//  - Outputs: combinational decode of registered state + ir; in RESET all 0.
//  - clr=0: state->RESET, wait counter and sticky flags cleared, all outputs 0 at
//    once, even mid-instruction. First clk after release: RESET->T0.
//  - Fetch: T0 PCout,MARin,IncPC,Zin. T1 Zlowout,PCin,Read,MDRin. T2 MDRout,IRin.
//  - T1 holds while mem_ready=0. Repeated PCin is idempotent because Z is unchanged.
//  - Opcode map: ld 00000, ldi 00001, st 00010, R-type 00011-01011 (alu_op=opcode),
//    brx 10010, nop 11010, halt 11011.
//  - R-type: T3 Grb,Rout,Yin; T4 Grc,Rout,alu_op,Zin; T5 Zlowout,Gra,Rin -> T0.
//  - ldi: T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin -> T0.
//  - ld: T3/T4 as ldi; T5 Zlowout,MARin; T6 Read,MDRin (hold until mem_ready);
//    T7 MDRout,Gra,Rin -> T0.
//  - st: T3-T5 as ld; T6 Gra,Rout,MDRin; T7 MDRout,Write (hold until mem_ready) -> T0.
//  - brx: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout,PCin only if
//    con_ff=1, else idle -> T0.
//  - nop: T2 -> T0. halt: T2 -> HALT.
//  - stop=1 in T0 -> HALT. It is ignored in other states.
//  - HALT is terminal until clr. In HALT all strobes=0 and run=0.
//  - Wait counter: zeroed on entering any memory-wait state; +1 per cycle with
//    mem_ready=0. Reaching WAIT_MAX -> HALT, mem_err=1.
//  - mem_ready=1 on the first wait cycle: zero stall, counter unused.
//  - mem_ready is ignored outside wait states.
// CONFIGURATION
//  CU_ILLEGAL_TRAP_EN defined: an unmapped opcode goes T2 -> HALT and sets illegal=1.
//  Undefined: an unmapped opcode executes as nop (T2 -> T0), and illegal is tied 0.
// TESTING
//  1 R2=0x12,R3=0x14, ir=0x28918000 (and R1,R2,R3), mem_ready=1 -> strobes per T0-T5
//    exactly; R1=0x10, back in T0 after 6 clks.
//  2 ld with mem_ready low 3 cycles in T6 -> Read,MDRin held 4 clks, then T7, no mem_err.
//  3 mem_ready never asserted in T1 -> HALT after WAIT_MAX=15 cycles; mem_err=1, run=0.
//  4 brx with con_ff=0 then con_ff=1 -> PCin absent / present in T6; PC=PC+1+C for taken.
//  5 clr=0 pulsed in T4 of add -> all outputs 0 same cycle; after release T0 fetch restarts.
//  6 opcode 11111: macro on -> HALT, illegal=1. Macro off -> T0, illegal=0.
//    stop=1 in T0 -> HALT.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the 32-bit single-bus datapath. Steps the fetch
// cycle (T0-T2) and the execute cycle (T3-T7) and decodes the registered step
// together with the opcode in IR into the datapath control strobes. Memory
// steps stretch on mem_ready; the sequencer halts on stop (sampled in T0), on
// the halt opcode, or when a memory step waits WAIT_MAX cycles.
//
// Optional feature macro: CU_ILLEGAL_TRAP_EN
//   defined   : an unmapped opcode goes T2 -> HALT and sets the sticky illegal flag
//   undefined : an unmapped opcode executes as nop (T2 -> T0), illegal tied 0
//
// Parameters
//   OPW       opcode width, taken from the top bits of ir
//   WAIT_MAX  cycles a Read/Write step may wait for mem_ready before mem_err
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous reset, active-low
//   ir         in   instruction register contents
//   con_ff     in   branch condition flip-flop from the datapath
//   mem_ready  in   memory completed the current Read/Write
//   stop       in   halt request, honoured only in T0
//   PCout, Zlowout, MDRout, BAout, Cout, Rout     out  bus drive enables
//   PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin out register load enables
//   Gra, Grb, Grc                                 out  IR register-field selects
//   IncPC, Read, Write                            out  ALU increment / memory strobes
//   alu_op     out  ALU opcode (ADD for address/branch arithmetic)
//   run        out  1 while executing, 0 in RESET/HALT
//   mem_err    out  sticky, memory timeout
//   illegal    out  sticky, unmapped opcode (trap build only)
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPW      = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [31:0]    ir,
    input  logic           con_ff,
    input  logic           mem_ready,
    input  logic           stop,
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           BAout,
    output logic           Cout,
    output logic           Rout,
    output logic           PCin,
    output logic           IRin,
    output logic           MARin,
    output logic           MDRin,
    output logic           Yin,
    output logic           Zin,
    output logic           Rin,
    output logic           CONin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           mem_err,
    output logic           illegal
);

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    localparam int CW = $clog2(WAIT_MAX + 1);
    // Timeout fires on the WAIT_MAX-th stalled cycle, i.e. when the count of
    // already-stalled cycles equals WAIT_MAX-1.
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

    localparam logic [OPW-1:0] OP_LD     = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI    = OPW'(1);
    localparam logic [OPW-1:0] OP_ST     = OPW'(2);
    localparam logic [OPW-1:0] OP_RFIRST = OPW'(3);
    localparam logic [OPW-1:0] OP_RLAST  = OPW'(11);
    localparam logic [OPW-1:0] OP_BRX    = OPW'(18);
    localparam logic [OPW-1:0] OP_NOP    = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT   = OPW'(27);
    localparam logic [OPW-1:0] ALU_ADD   = OPW'(3);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_nxt;
    logic            err_set;
`ifdef CU_ILLEGAL_TRAP_EN
    logic            ill_set;
`endif

    logic [OPW-1:0]  opcode;
    logic            is_ld;
    logic            is_ldi;
    logic            is_st;
    logic            is_rtype;
    logic            is_brx;
    logic            is_nop;
    logic            is_halt;
    logic            is_exec;
    logic            mem_wait;
    logic            timeout;

    // The register fields are consumed by the datapath through Gra/Grb/Grc;
    // the sequencer itself only decodes the opcode.
    logic            ir_unused;
    assign ir_unused = ^ir[31-OPW:0];

    assign opcode   = ir[31:32-OPW];
    assign is_ld    = (opcode == OP_LD);
    assign is_ldi   = (opcode == OP_LDI);
    assign is_st    = (opcode == OP_ST);
    assign is_rtype = (opcode >= OP_RFIRST) && (opcode <= OP_RLAST);
    assign is_brx   = (opcode == OP_BRX);
    assign is_nop   = (opcode == OP_NOP);
    assign is_halt  = (opcode == OP_HALT);
    assign is_exec  = is_ld | is_ldi | is_st | is_rtype | is_brx;

    // Steps that stall on mem_ready: fetch read, ld read, st write.
    assign mem_wait = (state == S_T1) ||
                      ((state == S_T6) && is_ld) ||
                      ((state == S_T7) && is_st);
    assign timeout  = (wait_cnt == WAIT_LAST);

    // -------------------------------------------------------------------------
    // State register, wait counter and sticky flags.
    // NOTE: clr forces RESET asynchronously, so every strobe (decoded from the
    // registered state) drops in the same cycle, even mid-instruction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_RESET;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values regardless of statement order.
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) begin
                mem_err <= 1'b1;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            if (ill_set) begin
                illegal <= 1'b1;
            end
`endif
        end
    end

`ifndef CU_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next state and strobe decode.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        wait_nxt  = '0;
        err_set   = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        ill_set   = 1'b0;
`endif
        {PCout, Zlowout, MDRout, BAout, Cout, Rout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin} = '0;
        {Gra, Grb, Grc, IncPC, Read, Write} = '0;
        alu_op = '0;
        run    = (state != S_RESET) && (state != S_HALT);

        case (state)
            S_RESET: state_nxt = S_T0;

            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                state_nxt = stop ? S_HALT : S_T1;
            end

            // Repeating PCin while stalled is harmless: Z still holds PC+1.
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_nxt = S_T2;
            end

            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else if (is_nop) begin
                    state_nxt = S_T0;
                end else if (is_exec) begin
                    state_nxt = S_T3;
                end else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
                    ill_set   = 1'b1;
`else
                    state_nxt = S_T0;
`endif
                end
            end

            S_T3: begin
                state_nxt = S_T4;
                if (is_brx) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (is_rtype) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else begin
                    // ld/ldi/st: base register, R0 reads as zero via BAout
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end
            end

            S_T4: begin
                state_nxt = S_T5;
                if (is_brx) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_rtype) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = ALU_ADD;
                end
            end

            S_T5: begin
                if (is_ld || is_st) begin
                    Zlowout   = 1'b1;
                    MARin     = 1'b1;
                    state_nxt = S_T6;
                end else if (is_brx) begin
                    Cout      = 1'b1;
                    Zin       = 1'b1;
                    alu_op    = ALU_ADD;
                    state_nxt = S_T6;
                end else begin
                    Zlowout   = 1'b1;
                    Gra       = 1'b1;
                    Rin       = 1'b1;
                    state_nxt = S_T0;
                end
            end

            S_T6: begin
                if (is_ld) begin
                    Read      = 1'b1;
                    MDRin     = 1'b1;
                    state_nxt = S_T7;
                end else if (is_st) begin
                    Gra       = 1'b1;
                    Rout      = 1'b1;
                    MDRin     = 1'b1;
                    state_nxt = S_T7;
                end else begin
                    // brx: the computed target is only taken when con_ff is set
                    Zlowout   = con_ff;
                    PCin      = con_ff;
                    state_nxt = S_T0;
                end
            end

            S_T7: begin
                MDRout    = 1'b1;
                state_nxt = S_T0;
                if (is_st) begin
                    Write = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end

            S_HALT: state_nxt = S_HALT;

            default: state_nxt = S_RESET;
        endcase

        // Memory stall overrides the advance chosen above. The counter is
        // zero whenever a wait step is entered because it defaults to zero
        // on every non-holding cycle.
        if (mem_wait && !mem_ready) begin
            if (timeout) begin
                state_nxt = S_HALT;
                err_set   = 1'b1;
            end else begin
                state_nxt = state;
                wait_nxt  = wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Directed bench for control_sequencer. A small bus datapath (PC, MAR, MDR,
// Y, Z, register file, memory) reacts to the strobes so register and PC
// results can be checked alongside the per-step strobe patterns. ir, con_ff,
// mem_ready and stop are driven directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic        stop;

    logic PCout, Zlowout, MDRout, BAout, Cout, Rout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [4:0] alu_op;
    logic run, mem_err, illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_sequencer #(.OPW(5), .WAIT_MAX(15)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .BAout(BAout),
        .Cout(Cout), .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .Rin(Rin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
        .Write(Write), .alu_op(alu_op), .run(run), .mem_err(mem_err),
        .illegal(illegal)
    );

    // Strobe vector, MSB first in port order.
    logic [19:0] strobes;
    assign strobes = {PCout, Zlowout, MDRout, BAout, Cout, Rout, PCin, IRin,
                      MARin, MDRin, Yin, Zin, Rin, CONin, Gra, Grb, Grc,
                      IncPC, Read, Write};

    localparam logic [19:0] M_PCOUT  = 20'h80000, M_ZLOW  = 20'h40000;
    localparam logic [19:0] M_MDROUT = 20'h20000, M_BAOUT = 20'h10000;
    localparam logic [19:0] M_COUT   = 20'h08000, M_ROUT  = 20'h04000;
    localparam logic [19:0] M_PCIN   = 20'h02000, M_IRIN  = 20'h01000;
    localparam logic [19:0] M_MARIN  = 20'h00800, M_MDRIN = 20'h00400;
    localparam logic [19:0] M_YIN    = 20'h00200, M_ZIN   = 20'h00100;
    localparam logic [19:0] M_RIN    = 20'h00080, M_CONIN = 20'h00040;
    localparam logic [19:0] M_GRA    = 20'h00020, M_GRB   = 20'h00010;
    localparam logic [19:0] M_GRC    = 20'h00008, M_INCPC = 20'h00004;
    localparam logic [19:0] M_READ   = 20'h00002, M_WRITE = 20'h00001;

    localparam logic [19:0] F0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [19:0] F1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [19:0] F2  = M_MDROUT | M_IRIN;
    localparam logic [19:0] R3  = M_GRB | M_ROUT | M_YIN;
    localparam logic [19:0] R4  = M_GRC | M_ROUT | M_ZIN;
    localparam logic [19:0] R5  = M_ZLOW | M_GRA | M_RIN;
    localparam logic [19:0] I3  = M_GRB | M_BAOUT | M_YIN;
    localparam logic [19:0] I4  = M_COUT | M_ZIN;
    localparam logic [19:0] L5  = M_ZLOW | M_MARIN;
    localparam logic [19:0] L6  = M_READ | M_MDRIN;
    localparam logic [19:0] L7  = M_MDROUT | M_GRA | M_RIN;
    localparam logic [19:0] S6  = M_GRA | M_ROUT | M_MDRIN;
    localparam logic [19:0] S7  = M_MDROUT | M_WRITE;
    localparam logic [19:0] B3  = M_GRA | M_ROUT | M_CONIN;
    localparam logic [19:0] B4  = M_PCOUT | M_YIN;
    localparam logic [19:0] B5  = M_COUT | M_ZIN;
    localparam logic [19:0] B6T = M_ZLOW | M_PCIN;
    localparam logic [19:0] NONE = 20'h0;

    localparam logic [31:0] IR_AND  = 32'h28918000; // and R1,R2,R3
    localparam logic [31:0] IR_LD   = 32'h02000030; // ld  R4,0x30(R0)
    localparam logic [31:0] IR_ST   = 32'h10800031; // st  0x31(R0),R1
    localparam logic [31:0] IR_BRX  = 32'h90800005; // brx R1,+5
    localparam logic [31:0] IR_ADD  = 32'h1A918000; // add R5,R2,R3
    localparam logic [31:0] IR_BAD  = 32'hF8000000; // opcode 11111
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    // ---------------- datapath model ----------------
    logic [31:0] pc, mar, mdr, y, z, bus, c_sext;
    logic [31:0] rf  [16];
    logic [31:0] mem [64];
    logic [3:0]  sel;

    function automatic logic [31:0] alu(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            5'd3:    return a + b;
            5'd4:    return a - b;
            5'd5:    return a & b;
            5'd6:    return a | b;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        c_sext = {{13{ir[18]}}, ir[18:0]};
        sel = 4'd0;
        if (Gra)      sel = ir[26:23];
        else if (Grb) sel = ir[22:19];
        else if (Grc) sel = ir[18:15];
        bus = 32'h0;
        if (PCout)        bus = pc;
        else if (Zlowout) bus = z;
        else if (MDRout)  bus = mdr;
        else if (BAout)   bus = (sel == 4'd0) ? 32'h0 : rf[sel];
        else if (Cout)    bus = c_sext;
        else if (Rout)    bus = rf[sel];
    end

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc  <= 32'h20;
            mar <= 32'h0;
            mdr <= 32'h0;
            y   <= 32'h0;
            z   <= 32'h0;
            for (int i = 0; i < 16; i++) rf[i] <= 32'h0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            rf[2]     <= 32'h12;
            rf[3]     <= 32'h14;
            mem[6'h30] <= 32'hCAFEF00D;
        end else begin
            if (PCin)  pc  <= bus;
            if (MARin) mar <= bus;
            if (Yin)   y   <= bus;
            if (Zin)   z   <= IncPC ? bus + 32'd1 : alu(alu_op, y, bus);
            if (Rin)   rf[sel] <= bus;
            if (MDRin) begin
                if (!Read)         mdr <= bus;
                else if (mem_ready) mdr <= mem[mar[5:0]];
            end
            if (Write && mem_ready) mem[mar[5:0]] <= mdr;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [19:0] exp_s,
                        input logic [4:0] exp_alu, input logic exp_run);
        check({tag, "_strobes"}, {12'h0, strobes}, {12'h0, exp_s});
        check({tag, "_alu_op"},  {27'h0, alu_op},  {27'h0, exp_alu});
        check({tag, "_run"},     {31'h0, run},     {31'h0, exp_run});
    endtask

    // Leaves the sequencer in T0.
    task automatic reset_pulse();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        clr = 1'b0; ir = 32'h0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0;
        tick();
        step("reset", NONE, 5'd0, 1'b0);
        check("reset_mem_err", {31'h0, mem_err}, 32'h0);
        check("reset_illegal", {31'h0, illegal}, 32'h0);

        // and R1,R2,R3 with zero-stall memory
        clr = 1'b1;
        ir  = IR_AND;
        tick(); step("and_t0", F0, 5'd0, 1'b1);
        tick(); step("and_t1", F1, 5'd0, 1'b1);
        tick(); step("and_t2", F2, 5'd0, 1'b1);
        tick(); step("and_t3", R3, 5'd0, 1'b1);
        tick(); step("and_t4", R4, 5'b00101, 1'b1);
        tick(); step("and_t5", R5, 5'd0, 1'b1);
        tick(); step("and_back_t0", F0, 5'd0, 1'b1);
        check("and_r1", rf[1], 32'h10);
        check("and_pc", pc, 32'h21);

        // ld with mem_ready low for three T6 cycles
        ir = IR_LD;
        tick(); step("ld_t1", F1, 5'd0, 1'b1);
        tick(); step("ld_t2", F2, 5'd0, 1'b1);
        tick(); step("ld_t3", I3, 5'd0, 1'b1);
        tick(); step("ld_t4", I4, 5'd3, 1'b1);
        tick(); step("ld_t5", L5, 5'd0, 1'b1);
        mem_ready = 1'b0;
        tick(); step("ld_wait1", L6, 5'd0, 1'b1);
        tick(); step("ld_wait2", L6, 5'd0, 1'b1);
        tick(); step("ld_wait3", L6, 5'd0, 1'b1);
        mem_ready = 1'b1;
        step("ld_wait4", L6, 5'd0, 1'b1);
        tick(); step("ld_t7", L7, 5'd0, 1'b1);
        check("ld_no_mem_err", {31'h0, mem_err}, 32'h0);
        tick(); step("ld_back_t0", F0, 5'd0, 1'b1);
        check("ld_r4", rf[4], 32'hCAFEF00D);

        // st R1 to 0x31
        ir = IR_ST;
        tick(); tick(); tick(); tick();
        tick(); step("st_t5", L5, 5'd0, 1'b1);
        tick(); step("st_t6", S6, 5'd0, 1'b1);
        tick(); step("st_t7", S7, 5'd0, 1'b1);
        tick(); step("st_back_t0", F0, 5'd0, 1'b1);
        check("st_mem", mem[6'h31], 32'h10);

        // brx not taken, then taken
        ir = IR_BRX;
        con_ff = 1'b0;
        tick(); tick();
        tick(); step("brx_t3", B3, 5'd0, 1'b1);
        tick(); step("brx_t4", B4, 5'd0, 1'b1);
        tick(); step("brx_t5", B5, 5'd3, 1'b1);
        tick(); step("brx_nt_t6", NONE, 5'd0, 1'b1);
        tick(); step("brx_nt_t0", F0, 5'd0, 1'b1);
        check("brx_nt_pc", pc, 32'h24);
        con_ff = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        tick(); step("brx_tk_t6", B6T, 5'd0, 1'b1);
        tick(); step("brx_tk_t0", F0, 5'd0, 1'b1);
        check("brx_tk_pc", pc, 32'h2A);
        con_ff = 1'b0;

        // clr pulsed in T4 of add
        ir = IR_ADD;
        tick(); tick(); tick();
        tick(); step("add_t4", R4, 5'd3, 1'b1);
        #1;
        clr = 1'b0;
        #1;
        step("clr_async", NONE, 5'd0, 1'b0);
        tick(); step("clr_held", NONE, 5'd0, 1'b0);
        clr = 1'b1;
        tick(); step("restart_t0", F0, 5'd0, 1'b1);
        tick(); step("restart_t1", F1, 5'd0, 1'b1);

        // unmapped opcode
        ir = IR_BAD;
        tick(); step("bad_t2", F2, 5'd0, 1'b1);
        tick();
`ifdef CU_ILLEGAL_TRAP_EN
        step("bad_halt", NONE, 5'd0, 1'b0);
        check("bad_illegal", {31'h0, illegal}, 32'h1);
`else
        step("bad_as_nop", F0, 5'd0, 1'b1);
        check("bad_illegal", {31'h0, illegal}, 32'h0);
`endif
        clr = 1'b0;
        tick();
        check("illegal_cleared", {31'h0, illegal}, 32'h0);
        clr = 1'b1;
        tick(); step("after_bad_t0", F0, 5'd0, 1'b1);

        // nop with stop raised outside T0, then honoured in T0
        ir = IR_NOP;
        tick();
        stop = 1'b1;
        tick(); step("stop_ignored_t2", F2, 5'd0, 1'b1);
        tick(); step("nop_t0", F0, 5'd0, 1'b1);
        tick(); step("stop_halt", NONE, 5'd0, 1'b0);
        stop = 1'b0;
        tick(); tick(); step("halt_terminal", NONE, 5'd0, 1'b0);
        reset_pulse();

        // halt opcode
        ir = IR_HALT;
        tick(); tick();
        tick(); step("halt_op", NONE, 5'd0, 1'b0);
        check("halt_op_no_err", {31'h0, mem_err}, 32'h0);
        reset_pulse();

        // fetch read never acknowledged: 15 stalled cycles in T1
        ir = IR_NOP;
        mem_ready = 1'b0;
        tick();
        repeat (14) tick();
        step("wait_15th", F1, 5'd0, 1'b1);
        check("wait_no_err", {31'h0, mem_err}, 32'h0);
        tick(); step("timeout_halt", NONE, 5'd0, 1'b0);
        check("timeout_mem_err", {31'h0, mem_err}, 32'h1);
        mem_ready = 1'b1;
        tick(); step("timeout_stays", NONE, 5'd0, 1'b0);
        check("mem_err_sticky", {31'h0, mem_err}, 32'h1);
        reset_pulse();
        check("mem_err_cleared", {31'h0, mem_err}, 32'h0);
        step("final_t0", F0, 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
